row_fetch_ctrl: RTL and testbench

ROW_FETCH_CTRL -- requirements
Module: row_fetch_ctrl

---
 rtl/row_fetch_ctrl_pkg.sv | 20 ++
 rtl/row_fetch_ctrl_if.sv | 48 ++++
 rtl/row_fetch_ctrl_lat_pipe.sv | 28 ++
 rtl/row_fetch_ctrl.sv | 129 ++++++++++++
 tb/tb_row_fetch_ctrl.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/row_fetch_ctrl_pkg.sv
// Shared defaults and FSM state encoding for the row fetch controller.
package row_fetch_ctrl_pkg;

  localparam int unsigned ImSizeDef = 32;
  localparam int unsigned AddrWDef  = 10;
  localparam int unsigned RomLatDef = 1;

  localparam int unsigned RowW   = 5;
  localparam int unsigned SelW   = 4;
  localparam int unsigned DrainW = 2;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StDrain,
    StRowRdy,
    StDone
  } state_e;

endpackage

// File: rtl/row_fetch_ctrl_if.sv
// Control, ROM-side and row-handshake signals of the row fetch controller.
interface row_fetch_ctrl_if
  import row_fetch_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = AddrWDef
) ();

  logic              start;
  logic              next_sample;
  logic              row_ready;
  logic              rom_en;
  logic [ADDR_W-1:0] rom_addr;
  logic              shift_en;
  logic              row_valid;
  logic [RowW-1:0]   row_idx;
  logic [SelW-1:0]   sample_sel;
  logic              busy;
  logic              frame_done;

  modport master (
    input  start,
    input  next_sample,
    input  row_ready,
    output rom_en,
    output rom_addr,
    output shift_en,
    output row_valid,
    output row_idx,
    output sample_sel,
    output busy,
    output frame_done
  );

  modport slave (
    output start,
    output next_sample,
    output row_ready,
    input  rom_en,
    input  rom_addr,
    input  shift_en,
    input  row_valid,
    input  row_idx,
    input  sample_sel,
    input  busy,
    input  frame_done
  );

endinterface

// File: rtl/row_fetch_ctrl_lat_pipe.sv
// Depth-deep 1-bit delay line with synchronous clear; aligns shift_en with ROM read data.
module row_fetch_ctrl_lat_pipe #(
  parameter int unsigned Depth = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic d,
  output logic q
);

  logic [Depth-1:0] pipe_q;
  logic [Depth:0]   pipe_in;

  assign pipe_in = {pipe_q, d};
  assign q       = pipe_q[Depth-1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pipe_q <= '0;
    end else if (clr) begin
      pipe_q <= '0;
    end else begin
      pipe_q <= pipe_in[Depth-1:0];
    end
  end

endmodule

// File: rtl/row_fetch_ctrl.sv
// Fetches an IM_SIZE x IM_SIZE frame from ROM row by row, presenting each completed row
// downstream with a valid/ready handshake.
module row_fetch_ctrl
  import row_fetch_ctrl_pkg::*;
#(
  parameter int unsigned IM_SIZE = ImSizeDef,
  parameter int unsigned ADDR_W  = AddrWDef,
  parameter int unsigned ROM_LAT = RomLatDef
) (
  input logic             clk,
  input logic             rst,
  row_fetch_ctrl_if.master bus
);

  localparam int unsigned ColW = (IM_SIZE > 1) ? $clog2(IM_SIZE) : 1;

  state_e            state_q, state_d;
  logic [ColW-1:0]   col_q, col_d;
  logic [DrainW-1:0] drain_q, drain_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [RowW-1:0]   row_q, row_d;
  logic [SelW-1:0]   sel_q, sel_d;
  logic              rom_en;
  logic              shift_en;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      col_q   <= '0;
      drain_q <= '0;
      addr_q  <= '0;
      row_q   <= '0;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      drain_q <= drain_d;
      addr_q  <= addr_d;
      row_q   <= row_d;
      sel_q   <= sel_d;
    end
  end

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    drain_d = drain_q;
    addr_d  = addr_q;
    row_d   = row_q;
    sel_d   = sel_q;

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          state_d = StFetch;
          addr_d  = '0;
          row_d   = '0;
          col_d   = '0;
        end
      end
      StFetch: begin
        // The address runs on across rows; it only returns to 0 at frame end or abort.
        addr_d = addr_q + 1'b1;
        col_d  = col_q + 1'b1;
        if (col_q == ColW'(IM_SIZE - 1)) begin
          state_d = StDrain;
          drain_d = '0;
        end
      end
      StDrain: begin
        drain_d = drain_q + 1'b1;
        if (drain_q == DrainW'(ROM_LAT - 1)) begin
          state_d = StRowRdy;
        end
      end
      StRowRdy: begin
        if (bus.row_ready) begin
          if (row_q == RowW'(IM_SIZE - 1)) begin
            state_d = StDone;
            addr_d  = '0;
            row_d   = '0;
          end else begin
            state_d = StFetch;
            row_d   = row_q + 1'b1;
            col_d   = '0;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Sample switch aborts whatever is in flight, including a same-cycle start or row handshake.
    if (bus.next_sample) begin
      sel_d   = sel_q + 1'b1;
      state_d = StIdle;
      addr_d  = '0;
      row_d   = '0;
      col_d   = '0;
      drain_d = '0;
    end
  end

  assign rom_en = (state_q == StFetch);

  row_fetch_ctrl_lat_pipe #(
    .Depth (ROM_LAT)
  ) u_lat_pipe (
    .clk (clk),
    .rst (rst),
    .clr (bus.next_sample),
    .d   (rom_en),
    .q   (shift_en)
  );

  assign bus.rom_en     = rom_en;
  assign bus.rom_addr   = addr_q;
  assign bus.shift_en   = shift_en;
  assign bus.row_valid  = (state_q == StRowRdy);
  assign bus.row_idx    = row_q;
  assign bus.sample_sel = sel_q;
  assign bus.busy       = (state_q != StIdle);
  assign bus.frame_done = (state_q == StDone);

endmodule

// File: tb/tb_row_fetch_ctrl.sv
// Directed bench for row_fetch_ctrl: one instance with ROM_LAT=1 and one with ROM_LAT=3.
module tb_row_fetch_ctrl;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  row_fetch_ctrl_if #(.ADDR_W(10)) bus_a ();
  row_fetch_ctrl_if #(.ADDR_W(10)) bus_b ();

  row_fetch_ctrl #(.IM_SIZE(32), .ADDR_W(10), .ROM_LAT(1)) u_dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  row_fetch_ctrl #(.IM_SIZE(32), .ADDR_W(10), .ROM_LAT(3)) u_dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " rom_en"}, int'(bus_a.rom_en), 0);
    chk({tag, " shift_en"}, int'(bus_a.shift_en), 0);
    chk({tag, " row_valid"}, int'(bus_a.row_valid), 0);
    chk({tag, " busy"}, int'(bus_a.busy), 0);
    chk({tag, " frame_done"}, int'(bus_a.frame_done), 0);
    chk({tag, " rom_addr"}, int'(bus_a.rom_addr), 0);
    chk({tag, " row_idx"}, int'(bus_a.row_idx), 0);
    chk({tag, " sample_sel"}, int'(bus_a.sample_sel), 0);
  endtask

  initial begin
    int n_rom, n_shift, n_rv, n_fd, bad_addr, bad_shift, exp_addr, max_addr, bad, n_en;
    bit prev_rom, seen;
    logic [2:0] hist;
    int first_rom, first_shift, last_rom0, last_shift0, first_rv;

    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    bus_a.start = 1'b0; bus_a.next_sample = 1'b0; bus_a.row_ready = 1'b0;
    bus_b.start = 1'b0; bus_b.next_sample = 1'b0; bus_b.row_ready = 1'b0;
    #2 rst = 1'b0;
    repeat (3) step();
    chk_reset_vals("reset");
    rst = 1'b1;
    step();

    // Full frame, row_ready tied high.
    bus_a.row_ready = 1'b1;
    bus_a.start = 1'b1;
    step();
    bus_a.start = 1'b0;
    chk("start latency rom_en", int'(bus_a.rom_en), 1);
    chk("start rom_addr", int'(bus_a.rom_addr), 0);
    n_rom = 0; n_shift = 0; n_rv = 0; n_fd = 0;
    bad_addr = 0; bad_shift = 0; exp_addr = 0; max_addr = 0; prev_rom = 1'b0;
    for (int i = 0; i < 1200; i++) begin
      if (bus_a.rom_en) begin
        n_rom++;
        if (int'(bus_a.rom_addr) != exp_addr) bad_addr++;
        if (int'(bus_a.rom_addr) > max_addr) max_addr = int'(bus_a.rom_addr);
        exp_addr++;
      end
      if (bus_a.shift_en !== prev_rom) bad_shift++;
      prev_rom = bus_a.rom_en;
      if (bus_a.shift_en) n_shift++;
      if (bus_a.row_valid) n_rv++;
      if (bus_a.frame_done) n_fd++;
      step();
    end
    chk("frame rom_en count", n_rom, 1024);
    chk("frame shift_en count", n_shift, 1024);
    chk("frame row_valid count", n_rv, 32);
    chk("frame frame_done count", n_fd, 1);
    chk("frame addr sequence errors", bad_addr, 0);
    chk("frame max rom_addr", max_addr, 1023);
    chk("frame shift_en alignment errors", bad_shift, 0);
    chk("frame rom_addr after", int'(bus_a.rom_addr), 0);
    chk("frame busy after", int'(bus_a.busy), 0);

    // Stall at row 0, then advance to row 5 and abort with next_sample.
    bus_a.row_ready = 1'b0;
    bus_a.start = 1'b1;
    step();
    bus_a.start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      if (bus_a.row_valid) seen = 1'b1;
      else step();
    end
    chk("stall row_valid reached", int'(seen), 1);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus_a.row_valid !== 1'b1 || bus_a.rom_en !== 1'b0 || bus_a.rom_addr !== 10'd32
          || bus_a.row_idx !== 5'd0) bad++;
      bus_a.start = (i == 10);
      step();
    end
    bus_a.start = 1'b0;
    chk("stall hold errors", bad, 0);
    bus_a.row_ready = 1'b1;
    step();
    chk("handshake latency rom_en", int'(bus_a.rom_en), 1);
    chk("handshake row_valid drop", int'(bus_a.row_valid), 0);
    chk("handshake row_idx", int'(bus_a.row_idx), 1);
    chk("handshake rom_addr continues", int'(bus_a.rom_addr), 32);
    seen = 1'b0;
    for (int i = 0; i < 400 && !seen; i++) begin
      if (bus_a.row_idx == 5'd5 && bus_a.rom_en) seen = 1'b1;
      else step();
    end
    chk("reach row 5", int'(seen), 1);
    repeat (3) step();
    bus_a.next_sample = 1'b1;
    step();
    bus_a.next_sample = 1'b0;
    bus_a.row_ready = 1'b0;
    chk("abort busy", int'(bus_a.busy), 0);
    chk("abort sample_sel", int'(bus_a.sample_sel), 1);
    chk("abort rom_addr", int'(bus_a.rom_addr), 0);
    chk("abort row_idx", int'(bus_a.row_idx), 0);
    chk("abort frame_done", int'(bus_a.frame_done), 0);
    n_en = 0;
    for (int i = 0; i < 5; i++) begin
      if (bus_a.shift_en || bus_a.rom_en) n_en++;
      step();
    end
    chk("abort no strobes", n_en, 0);

    // sample_sel wrap; next_sample beats a simultaneous start.
    for (int i = 0; i < 15; i++) begin
      bus_a.next_sample = 1'b1;
      step();
      bus_a.next_sample = 1'b0;
      step();
    end
    chk("sample_sel wrap to 0", int'(bus_a.sample_sel), 0);
    bus_a.next_sample = 1'b1;
    step();
    bus_a.next_sample = 1'b0;
    chk("sample_sel after 16", int'(bus_a.sample_sel), 1);
    bus_a.start = 1'b1;
    bus_a.next_sample = 1'b1;
    step();
    bus_a.start = 1'b0;
    bus_a.next_sample = 1'b0;
    chk("start+next busy", int'(bus_a.busy), 0);
    chk("start+next rom_en", int'(bus_a.rom_en), 0);
    chk("start+next sample_sel", int'(bus_a.sample_sel), 2);
    step();
    chk("start+next busy later", int'(bus_a.busy), 0);

    // Asynchronous reset in the middle of row 10.
    bus_a.row_ready = 1'b1;
    bus_a.start = 1'b1;
    step();
    bus_a.start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 600 && !seen; i++) begin
      if (bus_a.row_idx == 5'd10 && bus_a.rom_en) seen = 1'b1;
      else step();
    end
    chk("reach row 10", int'(seen), 1);
    #3 rst = 1'b0;
    #1;
    chk_reset_vals("async reset");
    step();
    step();
    rst = 1'b1;
    n_en = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (bus_a.shift_en || bus_a.rom_en) n_en++;
    end
    chk("post reset no strobes", n_en, 0);
    bus_a.start = 1'b1;
    step();
    bus_a.start = 1'b0;
    chk("restart rom_en", int'(bus_a.rom_en), 1);
    chk("restart rom_addr", int'(bus_a.rom_addr), 0);
    bus_a.next_sample = 1'b1;
    step();
    bus_a.next_sample = 1'b0;
    bus_a.row_ready = 1'b0;

    // ROM_LAT=3 full frame.
    bus_b.row_ready = 1'b1;
    bus_b.start = 1'b1;
    step();
    bus_b.start = 1'b0;
    hist = 3'b000; bad_shift = 0; n_shift = 0; n_fd = 0;
    first_rom = -1; first_shift = -1; last_rom0 = -1; last_shift0 = -1; first_rv = -1;
    for (int cyc = 0; cyc < 1300; cyc++) begin
      if (bus_b.shift_en !== hist[2]) bad_shift++;
      if (bus_b.rom_en && first_rom < 0) first_rom = cyc;
      if (bus_b.shift_en && first_shift < 0) first_shift = cyc;
      if (bus_b.rom_en && bus_b.row_idx == 5'd0) last_rom0 = cyc;
      if (bus_b.shift_en && bus_b.row_idx == 5'd0) last_shift0 = cyc;
      if (bus_b.row_valid && first_rv < 0) first_rv = cyc;
      if (bus_b.shift_en) n_shift++;
      if (bus_b.frame_done) n_fd++;
      hist = {hist[1:0], bus_b.rom_en};
      step();
    end
    chk("lat3 shift_en alignment errors", bad_shift, 0);
    chk("lat3 first shift delay", first_shift - first_rom, 3);
    chk("lat3 last shift delay", last_shift0 - last_rom0, 3);
    chk("lat3 row_valid after last shift", first_rv - last_shift0, 1);
    chk("lat3 shift_en count", n_shift, 1024);
    chk("lat3 frame_done count", n_fd, 1);
    chk("lat3 rom_addr after", int'(bus_b.rom_addr), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
